// File: rtl/paged_mem_ctrl.sv
// Paged data-memory controller: forms {mem_page, offset}, runs one outstanding
// req/ack access and stalls the CPU until it completes. ACCESS_TIMEOUT_EN adds a BUSY watchdog.
module paged_mem_ctrl #(
    parameter int PAGE_W   = 3,
    parameter int OFFSET_W = 5,
    parameter int DATA_W   = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PAGE_W-1:0]          mem_page,
    input  logic [OFFSET_W-1:0]        offset,
    input  logic                       rd_en,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       stall,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       err,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [PAGE_W+OFFSET_W-1:0] mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_ack,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       dbg_state
);

    localparam int ADDR_W = PAGE_W + OFFSET_W;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("paged_mem_ctrl: TIMEOUT must be at least 1");
    end

    // Handshake: mem_req is a level; request/address/data stay frozen from
    // accept until the first posedge that samples mem_ack high.
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                req_q, req_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                err_q, err_d;

    logic accept;
    logic illegal;
    logic timeout_hit;

    assign accept  = (state_q == IDLE) && (rd_en ^ wr_en);
    assign illegal = (state_q == IDLE) && rd_en && wr_en;

`ifdef ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Abort on the edge where the counter would reach TIMEOUT; an ack there wins.
    assign timeout_hit = (state_q == BUSY) && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if ((state_q == BUSY) && !mem_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack || timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        req_d      = req_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        err_d      = illegal;
        if (accept) begin
            addr_d  = {mem_page, offset};
            we_d    = wr_en;
            wdata_d = wr_data;
            req_d   = 1'b1;
        end else if (state_q == BUSY) begin
            if (mem_ack) begin
                req_d = 1'b0;
                if (!we_q) begin
                    rd_data_d  = mem_rdata;
                    rd_valid_d = 1'b1;
                end
            end else if (timeout_hit) begin
                req_d = 1'b0;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            req_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            req_q      <= req_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign stall     = accept || (state_q == BUSY);
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
